moore_seq_detector_param: RTL and testbench

Parametrised Moore-style serial sequence detector, successor to the fixed-pattern non-overlapping detector. Samples a 1-bit serial stream and pulses `dout` for one cycle when the last `PAT_W` accepted bits equal a runtime-loadable pattern. Detection can run in overlapping or non-overlapping mode, and a saturating counter records the number of matches. It sits between a serial input front-end and control logic that consumes single-cycle match strobes.

---
 rtl/seq_det_pkg.sv | 13 +
 rtl/seq_match_cmp.sv | 27 ++
 rtl/moore_seq_detector_param.sv | 97 +++++++++
 tb/tb_moore_seq_detector_param.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants for the parametrised serial sequence detector.
// Imported by the compare sub-module and the detector top.
package seq_det_pkg;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 32;

  localparam logic MODE_NOVL = 1'b0;
  localparam logic MODE_OVL  = 1'b1;

  localparam logic [3:0] DEF_PAT = 4'b1010;

endpackage

// File: rtl/seq_match_cmp.sv
// Combinational shift-and-compare step for the sequence detector.
// Produces the next history, next fill and the match flag.
module seq_match_cmp
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int FW    = $clog2(PAT_W + 1)
) (
  input  logic [PAT_W-1:0] hist_i,
  input  logic [FW-1:0]    fill_i,
  input  logic             din_i,
  input  logic [PAT_W-1:0] pat_i,
  output logic [PAT_W-1:0] nh_o,
  output logic [FW-1:0]    nf_o,
  output logic             hit_o
);

  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  assign nh_o = {hist_i[PAT_W-2:0], din_i};

  assign nf_o = (fill_i == FULL) ? fill_i
                                 : fill_i + FW'(1);

  assign hit_o = (nf_o == FULL) && (nh_o == pat_i);

endmodule

// File: rtl/moore_seq_detector_param.sv
// Moore serial sequence detector with loadable pattern,
// overlap mode and a saturating match counter.
module moore_seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(seq_det_pkg::DEF_PAT),
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [PAT_W-1:0] pat_q, pat_d;
  logic             ovl_q, ovl_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             dout_q, dout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PAT_W-1:0] nh;
  logic [FW-1:0]    nf;
  logic             hit;

  seq_match_cmp #(
    .PAT_W (PAT_W),
    .FW    (FW)
  ) u_cmp (
    .hist_i (hist_q),
    .fill_i (fill_q),
    .din_i  (din),
    .pat_i  (pat_q),
    .nh_o   (nh),
    .nf_o   (nf),
    .hit_o  (hit)
  );

  always_comb begin
    pat_d  = pat_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    dout_d = 1'b0;
    if (load) begin
      pat_d  = pattern;
      ovl_d  = overlap;
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (en) begin
      hist_d = nh;
      fill_d = nf;
      if (hit) begin
        dout_d = 1'b1;
        if (cnt_q != CMAX) cnt_d = cnt_q + CNT_W'(1);
        // non-overlap needs PAT_W fresh bits
        fill_d = (ovl_q == MODE_OVL) ? FULL : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q  <= DEF_PAT;
      ovl_q  <= MODE_NOVL;
      hist_q <= '0;
      fill_q <= '0;
      dout_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout      = dout_q;
  assign match_cnt = cnt_q;
  assign busy      = (fill_q != '0);

endmodule

// File: tb/tb_moore_seq_detector_param.sv
// Bench for moore_seq_detector_param: vector table, saturation
// sequence on a narrow instance, and a random run against a model.
module tb_moore_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, din, load, overlap;
  logic [3:0] pattern;
  logic       dout, busy;
  logic [7:0] match_cnt;

  logic       en1, din1, load1, ovl1;
  logic [1:0] pat1;
  logic       dout1, busy1;
  logic [1:0] cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  moore_seq_detector_param #(
    .PAT_W(4), .DEF_PAT(4'b1010), .CNT_W(8)
  ) u0 (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .load(load), .pattern(pattern), .overlap(overlap),
    .dout(dout), .match_cnt(match_cnt), .busy(busy)
  );

  moore_seq_detector_param #(
    .PAT_W(2), .DEF_PAT(2'b01), .CNT_W(2)
  ) u1 (
    .clk(clk), .rst(rst), .en(en1), .din(din1),
    .load(load1), .pattern(pat1), .overlap(ovl1),
    .dout(dout1), .match_cnt(cnt1), .busy(busy1)
  );

  typedef struct {
    logic       r, l, e, d, o;
    logic [3:0] p;
    logic       xd;
    logic [7:0] xc;
    logic       xb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic r, logic l, logic e, logic d, logic o,
    logic [3:0] p, logic xd, logic [7:0] xc, logic xb);
    vec_t v;
    v.r = r; v.l = l; v.e = e; v.d = d; v.o = o;
    v.p = p; v.xd = xd; v.xc = xc; v.xb = xb;
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic drive0(logic r, logic l, logic e,
                        logic d, logic o, logic [3:0] p);
    rst = r; load = l; en = e; din = d;
    overlap = o; pattern = p;
    @(posedge clk); #1;
  endtask

  task automatic drive1(logic l, logic e, logic d,
                        logic o, logic [1:0] p);
    load1 = l; en1 = e; din1 = d; ovl1 = o; pat1 = p;
    @(posedge clk); #1;
  endtask

  // reference: accepted bits since the last reset, load or
  // non-overlapping match; a match is the newest 4 equal to pattern
  bit         m_bits[$];
  logic [3:0] m_pat;
  logic       m_ovl;
  int         m_cnt;
  logic       m_dout;

  task automatic model(logic r, logic l, logic e,
                       logic d, logic o, logic [3:0] p);
    bit hit;
    m_dout = 1'b0;
    if (!r) begin
      m_bits.delete(); m_pat = 4'b1010; m_ovl = 0; m_cnt = 0;
    end else if (l) begin
      m_bits.delete(); m_pat = p; m_ovl = o; m_cnt = 0;
    end else if (e) begin
      m_bits.push_back(d);
      hit = (m_bits.size() >= 4);
      for (int i = 0; i < 4 && hit; i++)
        if (m_bits[m_bits.size() - 4 + i] != m_pat[3 - i]) hit = 0;
      if (hit) begin
        m_dout = 1'b1;
        if (m_cnt < 255) m_cnt++;
        if (!m_ovl) m_bits.delete();
      end
    end
  endtask

  initial begin
    rst = 0; load = 0; en = 0; din = 0; overlap = 0; pattern = 0;
    load1 = 0; en1 = 0; din1 = 0; ovl1 = 0; pat1 = 0;

    // reset defaults: 1010 non-overlap
    tbl.push_back(mk(0,0,0,0,0,4'h0, 0,0,0));
    tbl.push_back(mk(1,0,1,1,0,4'h0, 0,0,1));
    tbl.push_back(mk(1,0,1,0,0,4'h0, 0,0,1));
    tbl.push_back(mk(1,0,1,1,0,4'h0, 0,0,1));
    tbl.push_back(mk(1,0,1,0,0,4'h0, 1,1,0));
    tbl.push_back(mk(1,0,1,1,0,4'h0, 0,1,1));
    tbl.push_back(mk(1,0,1,0,0,4'h0, 0,1,1));
    // overlap 1010
    tbl.push_back(mk(1,1,1,1,1,4'hA, 0,0,0));
    tbl.push_back(mk(1,0,1,1,0,4'h0, 0,0,1));
    tbl.push_back(mk(1,0,1,0,0,4'h0, 0,0,1));
    tbl.push_back(mk(1,0,1,1,0,4'h0, 0,0,1));
    tbl.push_back(mk(1,0,1,0,0,4'h0, 1,1,1));
    tbl.push_back(mk(1,0,1,1,0,4'h0, 0,1,1));
    tbl.push_back(mk(1,0,1,0,0,4'h0, 1,2,1));
    // stalls, 1111 overlap
    tbl.push_back(mk(1,1,0,0,1,4'hF, 0,0,0));
    for (int k = 1; k <= 6; k++) begin
      tbl.push_back(mk(1,0,1,1,0,4'h0, k >= 4,
                       (k >= 4) ? 8'(k - 3) : 8'd0, 1));
      tbl.push_back(mk(1,0,0,1,0,4'h0, 0,
                       (k >= 4) ? 8'(k - 3) : 8'd0, 1));
    end
    // reset mid-sequence
    tbl.push_back(mk(1,1,0,0,0,4'hA, 0,0,0));
    tbl.push_back(mk(1,0,1,1,0,4'h0, 0,0,1));
    tbl.push_back(mk(1,0,1,0,0,4'h0, 0,0,1));
    tbl.push_back(mk(1,0,1,1,0,4'h0, 0,0,1));
    tbl.push_back(mk(0,0,0,0,0,4'h0, 0,0,0));
    tbl.push_back(mk(1,0,1,0,0,4'h0, 0,0,1));
    // load mid-sequence, load wins over en
    tbl.push_back(mk(1,1,0,0,0,4'hA, 0,0,0));
    tbl.push_back(mk(1,0,1,1,0,4'h0, 0,0,1));
    tbl.push_back(mk(1,0,1,0,0,4'h0, 0,0,1));
    tbl.push_back(mk(1,0,1,1,0,4'h0, 0,0,1));
    tbl.push_back(mk(1,1,1,0,0,4'hA, 0,0,0));
    tbl.push_back(mk(1,0,1,0,0,4'h0, 0,0,1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive0(tbl[i].r, tbl[i].l, tbl[i].e,
             tbl[i].d, tbl[i].o, tbl[i].p);
      chk($sformatf("vec%0d dout", i), dout, tbl[i].xd);
      chk($sformatf("vec%0d cnt", i), match_cnt, tbl[i].xc);
      chk($sformatf("vec%0d busy", i), busy, tbl[i].xb);
    end

    // saturation on the 2-bit instance, pattern 11 overlap
    drive1(1, 0, 0, 1, 2'b11);
    chk("sat load cnt", cnt1, 0);
    for (int k = 1; k <= 10; k++) begin
      drive1(0, 1, 1, 0, 2'b00);
      chk($sformatf("sat bit%0d dout", k), dout1, k >= 2);
      chk($sformatf("sat bit%0d cnt", k), cnt1,
          (k - 1 > 3) ? 3 : k - 1);
    end
    drive1(1, 0, 0, 0, 2'b11);
    chk("sat reload cnt", cnt1, 0);
    chk("sat reload busy", busy1, 0);

    // random run against the model
    model(0, 0, 0, 0, 0, 4'h0);
    drive0(0, 0, 0, 0, 0, 4'h0);
    for (int n = 0; n < 3000; n++) begin
      logic r, l, e, d, o;
      logic [3:0] p;
      r = ($urandom_range(0, 299) != 0);
      l = ($urandom_range(0, 39) == 0);
      e = ($urandom_range(0, 3) != 0);
      d = 1'($urandom);
      o = 1'($urandom);
      p = 4'($urandom);
      model(r, l, e, d, o, p);
      drive0(r, l, e, d, o, p);
      chk("rnd dout", dout, m_dout);
      chk("rnd cnt", match_cnt, m_cnt);
      chk("rnd busy", busy, m_bits.size() != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
